// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver with selectable baud rate,
// held output byte with valid/ack handshake, frame error and overrun.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   rx_in      serial line (asynchronous, idle high)
//   choose     baud select 00=9600 01=19200 10=38400 11=115200
//   rx_ack     consumer acknowledge, clears rx_valid and overrun
//   rx_data    last accepted byte
//   rx_valid   byte available, held until acknowledged
//   frame_err  one-cycle pulse on a bad stop bit
//   overrun    sticky, a byte was dropped while rx_valid was set
//   busy       receiver is inside a frame
module uart_rx_ctrl #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [1:0] choose,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV0 = CLK_FREQ / 9600;
    localparam int DIV1 = CLK_FREQ / 19200;
    localparam int DIV2 = CLK_FREQ / 38400;
    localparam int DIV3 = CLK_FREQ / 115200;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_nx;

    logic       rx_meta;
    logic       rx_s;
    logic       rx_prev;
    logic [1:0] fill;
    logic       armed;
    logic [1:0] div_sel;
    logic [15:0] baud_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [15:0] div_lim;
    logic [15:0] half_lim;

    logic start_det;
    logic half_hit;
    logic div_hit;
    logic cnt_clr;
    logic bit_clr;
    logic sample;
    logic accept;
    logic ferr;

    // Synchroniser and edge detect. The flops reset high, so a line
    // that is already low when reset releases would look like a
    // falling edge. fill marks when rx_s holds a real line sample,
    // and armed requires the line to have been seen high first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            fill    <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            fill    <= {fill[0], 1'b1};
            armed   <= armed | (fill[1] & rx_s);
        end
    end

    always_comb begin
        div_lim = 16'(DIV0);
        case (div_sel)
            2'b00:   div_lim = 16'(DIV0);
            2'b01:   div_lim = 16'(DIV1);
            2'b10:   div_lim = 16'(DIV2);
            default: div_lim = 16'(DIV3);
        endcase
        half_lim = div_lim >> 1;
    end

    assign start_det = (state == IDLE) & armed & rx_prev & ~rx_s;
    assign half_hit  = (baud_cnt == half_lim - 16'd1);
    assign div_hit   = (baud_cnt == div_lim - 16'd1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_det) state_nx = START;
            end
            START: begin
                if (half_hit) state_nx = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (div_hit && bit_cnt == 3'd7) state_nx = STOP;
            end
            STOP: begin
                if (div_hit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        cnt_clr = 1'b0;
        bit_clr = 1'b0;
        sample  = 1'b0;
        accept  = 1'b0;
        ferr    = 1'b0;
        busy    = (state != IDLE);
        case (state)
            IDLE: begin
                cnt_clr = start_det;
            end
            START: begin
                cnt_clr = half_hit;
                bit_clr = half_hit & ~rx_s;
            end
            DATA: begin
                cnt_clr = div_hit;
                sample  = div_hit;
            end
            STOP: begin
                cnt_clr = div_hit;
                accept  = div_hit & rx_s;
                ferr    = div_hit & ~rx_s;
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Bit timing and shift register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_sel  <= 2'b00;
            baud_cnt <= 16'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
        end else begin
            if (start_det) div_sel <= choose;
            if (cnt_clr) begin
                baud_cnt <= 16'd0;
            end else if (state != IDLE) begin
                baud_cnt <= baud_cnt + 16'd1;
            end
            if (bit_clr) begin
                bit_cnt <= 3'd0;
            end else if (sample) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (sample) shreg[bit_cnt] <= rx_s;
        end
    end

    // Handshake. An accept coinciding with rx_ack replaces the byte
    // and keeps rx_valid high, so the consumer never loses one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr;
            if (accept) begin
                if (!rx_valid) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else if (rx_ack) begin
                    rx_data <= shreg;
                    overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule
